syncfifo_read_ctrl: RTL and testbench
=====================================

# syncfifo_read_ctrl

Read-side pointer controller for synchronous FIFOs, the parametrised successor to the single-pop read pointer. It tracks the read pointer against the write pointer from the write-side controller. It supports popping up to MAX_POP entries per cycle, flushing, occupancy and almost-empty reporting, and error detection with a sticky flag. It sits between the FIFO storage array, which it addresses via `r_addr`, and the consumer.

## Interface
- `DEPTH`, default 8: number of entries; must be a power of two, at least 2.
- `MAX_POP`, default 4: largest pop count per cycle; 1 ≤ MAX_POP ≤ DEPTH.
- `AE_THRESH`, default 2: `almost_empty` asserts when occupancy ≤ AE_THRESH; 0 ≤ AE_THRESH < DEPTH.
- `PTR_WIDTH`, default $clog2(DEPTH)+1: pointer width with wrap bit; derived, not overridden.
- `CNT_WIDTH`, default $clog2(MAX_POP+1): width of `rcount`; derived.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ren`  in  1  pop request.
- `rcount`  in  CNT_WIDTH  entries to pop when `ren`=1.
- `flush`  in  1  discard all current entries.
- `err_clr`  in  1  clears `err_sticky`.
- `w_ptr`  in  PTR_WIDTH  write pointer from the write-side controller.
- `r_ptr`  out  PTR_WIDTH  current read pointer.
- `r_addr`  out  PTR_WIDTH-1  storage address, equal to `r_ptr[PTR_WIDTH-2:0]`.
- `count`  out  PTR_WIDTH  occupancy, 0..DEPTH.
- `empty`  out  1  `count`==0.
- `almost_empty`  out  1  `count` ≤ AE_THRESH.
- `pop_ok`  out  1  the current request is accepted this cycle.
- `rd_err`  out  1  the current request is rejected this cycle.
- `err_sticky`  out  1  latched `rd_err`.

## Operation
- `count` = (`w_ptr` − `r_ptr`) mod 2^PTR_WIDTH. `w_ptr` must never lead `r_ptr` by more than DEPTH; this is the write side's obligation and is not checked here.
- A request is valid when `ren`=1, 1 ≤ `rcount` ≤ MAX_POP and `rcount` ≤ `count`.
- `pop_ok` = valid & ~`flush`.
- `rd_err` = `ren` & ~`flush` & (`rcount`==0 | `rcount`>MAX_POP | `rcount`>`count`).
- Next `r_ptr`, in priority order:
  - `rst_n`=0 → 0.
  - `flush` → `w_ptr`, sampled this cycle.
  - `pop_ok` → `r_ptr` + `rcount`, zero-extended, modulo 2^PTR_WIDTH.
  - otherwise hold.
- A rejected request is all-or-nothing: no partial pop occurs and `r_ptr` holds.
- `err_sticky` next value, in priority order:
  - `rst_n`=0 → 0.
  - `rd_err` → 1 (set wins over a simultaneous `err_clr`).
  - `err_clr` → 0.
  - otherwise hold.
- `ren`=0 with any `rcount`: no-op, no error.
- Wrap-around: pointer arithmetic wraps naturally at 2^PTR_WIDTH. Full vs empty is distinguished by the MSB, so `count`==DEPTH when the low bits match and the MSBs differ.

## Timing
- `count`, `empty`, `almost_empty`, `pop_ok`, `rd_err` and `r_addr` are combinational from the current `r_ptr`, `w_ptr` and the inputs. Storage data at `r_addr` through `r_addr`+`rcount`−1 (mod DEPTH) is read in the same cycle as `pop_ok`.
- `r_ptr` and `err_sticky` update at the posedge after the request, so latency from request to pointer move is 1 cycle.
- Reset values:
  - `r_ptr`=0 and `err_sticky`=0.
  - The combinational outputs follow the state: with `w_ptr`=0, `count`=0, `empty`=1, `almost_empty`=1, `pop_ok`=0, `rd_err`=0.
- Reset during an active pop: reset wins and the pop is discarded.
- Flush and pop in the same cycle: flush wins, no error is raised, and `empty`=1 on the next cycle unless the write side pushed in that cycle.
- A write in the same cycle as a pop is not counted toward this cycle's validity; it is visible through `w_ptr` on the following cycle.

## Structure
- Package `syncfifo_pkg`:
  - `function ptr_width(depth)`.
  - `function occupancy(w_ptr, r_ptr)`.
  - A shared `syncfifo_err_e` enum: ERR_NONE, ERR_UNDERFLOW, ERR_BADCNT. This enum is used internally only to select the `rd_err` cause; it is not exposed on a port.
- One sub-module, `syncfifo_occupancy`: a combinational block computing `count`, `empty` and `almost_empty` from the two pointers. It is reused unchanged by the planned write-side controller (full / almost_full).
- Elaboration checks: DEPTH is a power of two, MAX_POP ≤ DEPTH, AE_THRESH < DEPTH.

## Test plan
All scenarios use DEPTH=8, MAX_POP=4, AE_THRESH=2.
- Reset then idle with `w_ptr`=0 → `r_ptr`=0, `empty`=1, `almost_empty`=1, `err_sticky`=0.
- `w_ptr`=5, `ren`=1, `rcount`=3 → `pop_ok`=1; next cycle `r_ptr`=3, `count`=2, `almost_empty`=1, `empty`=0.
- `w_ptr`=2, `r_ptr`=0, `rcount`=3 → `rd_err`=1; `r_ptr` holds at 0; `err_sticky`=1 next cycle. `err_clr` pulse → `err_sticky`=0 the cycle after.
- Wrap: `r_ptr`=14, `w_ptr`=3 (`count`=5), `rcount`=4 → `r_ptr`=2, `count`=1. Also, `r_ptr`=0 and `w_ptr`=8 → `count`=8, `empty`=0.
- `flush` with `ren`=1, `rcount`=2 and `w_ptr`=6 → `r_ptr`=6 next cycle, `empty`=1, `rd_err`=0. `rcount`=0 with `ren`=1 → `rd_err`=1. `rcount`=5 with `ren`=1 → `rd_err`=1.
- `rst_n`=0 asserted in the same cycle as a valid pop with `r_ptr`=4 → `r_ptr`=0 and `err_sticky`=0 next cycle.

Source files
------------

// File: rtl/syncfifo_pkg.sv
// Shared types and helpers for the synchronous FIFO pointer controllers.
package syncfifo_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_UNDERFLOW,
    ERR_BADCNT
  } syncfifo_err_e;

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Modular difference; callers truncate the result to their pointer width.
  function automatic logic [31:0] occupancy(input logic [31:0] w_ptr, input logic [31:0] r_ptr);
    return w_ptr - r_ptr;
  endfunction

endpackage

// File: rtl/syncfifo_occupancy.sv
// Combinational occupancy from a write/read pointer pair; shared by read and write controllers.
module syncfifo_occupancy
  import syncfifo_pkg::*;
#(
  parameter int PTR_WIDTH = 4,
  parameter int AE_THRESH = 2
) (
  input  logic [PTR_WIDTH-1:0] w_ptr,
  input  logic [PTR_WIDTH-1:0] r_ptr,
  output logic [PTR_WIDTH-1:0] count,
  output logic                 empty,
  output logic                 almost_empty
);

  always_comb begin
    count        = PTR_WIDTH'(occupancy(32'(w_ptr), 32'(r_ptr)));
    empty        = (count == '0);
    almost_empty = (count <= PTR_WIDTH'(AE_THRESH));
  end

endmodule

// File: rtl/syncfifo_read_ctrl.sv
// Read-side pointer controller: multi-entry pop, flush, occupancy and sticky error reporting.
module syncfifo_read_ctrl
  import syncfifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MAX_POP   = 4,
  parameter int AE_THRESH = 2,
  parameter int PTR_WIDTH = ptr_width(DEPTH),
  parameter int CNT_WIDTH = $clog2(MAX_POP + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ren,
  input  logic [CNT_WIDTH-1:0] rcount,
  input  logic                 flush,
  input  logic                 err_clr,
  input  logic [PTR_WIDTH-1:0] w_ptr,
  output logic [PTR_WIDTH-1:0] r_ptr,
  output logic [PTR_WIDTH-2:0] r_addr,
  output logic [PTR_WIDTH-1:0] count,
  output logic                 empty,
  output logic                 almost_empty,
  output logic                 pop_ok,
  output logic                 rd_err,
  output logic                 err_sticky
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("syncfifo_read_ctrl: DEPTH must be a power of two, at least 2");
  end
  if ((MAX_POP < 1) || (MAX_POP > DEPTH)) begin : g_bad_max_pop
    $error("syncfifo_read_ctrl: MAX_POP must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH >= DEPTH)) begin : g_bad_ae
    $error("syncfifo_read_ctrl: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PTR_WIDTH-1:0] r_ptr_reg, r_ptr_next;
  logic                 err_sticky_reg, err_sticky_next;
  logic [PTR_WIDTH-1:0] rcount_ext;
  syncfifo_err_e        err_cause;

  syncfifo_occupancy #(
    .PTR_WIDTH (PTR_WIDTH),
    .AE_THRESH (AE_THRESH)
  ) u_occupancy (
    .w_ptr        (w_ptr),
    .r_ptr        (r_ptr_reg),
    .count        (count),
    .empty        (empty),
    .almost_empty (almost_empty)
  );

  // A malformed count is reported ahead of underflow; flush suppresses both.
  always_comb begin
    rcount_ext = PTR_WIDTH'(rcount);
    err_cause  = ERR_NONE;
    if (ren && !flush) begin
      if ((rcount_ext == '0) || (rcount_ext > PTR_WIDTH'(MAX_POP)))
        err_cause = ERR_BADCNT;
      else if (rcount_ext > count)
        err_cause = ERR_UNDERFLOW;
    end
  end

  always_comb begin
    rd_err = (err_cause != ERR_NONE);
    pop_ok = ren && !flush && (err_cause == ERR_NONE);
  end

  always_comb begin
    r_ptr_next = r_ptr_reg;
    if (flush)
      r_ptr_next = w_ptr;
    else if (pop_ok)
      r_ptr_next = r_ptr_reg + rcount_ext;

    err_sticky_next = err_sticky_reg;
    if (rd_err)
      err_sticky_next = 1'b1;
    else if (err_clr)
      err_sticky_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr_reg      <= '0;
      err_sticky_reg <= 1'b0;
    end else begin
      r_ptr_reg      <= r_ptr_next;
      err_sticky_reg <= err_sticky_next;
    end
  end

  assign r_ptr      = r_ptr_reg;
  assign r_addr     = r_ptr_reg[PTR_WIDTH-2:0];
  assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_syncfifo_read_ctrl.sv
// Scoreboard bench for syncfifo_read_ctrl with DEPTH=8, MAX_POP=4, AE_THRESH=2.
module tb_syncfifo_read_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ren, flush, err_clr;
  logic [2:0] rcount;
  logic [3:0] w_ptr;
  logic [3:0] r_ptr, count;
  logic [2:0] r_addr;
  logic       empty, almost_empty, pop_ok, rd_err, err_sticky;

  typedef struct {
    string      name;
    logic [3:0] r_ptr;
    logic [3:0] count;
    logic       empty;
    logic       ae;
    logic       pop_ok;
    logic       rd_err;
    logic       sticky;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   check_cnt = 0;

  always #5 clk = ~clk;

  syncfifo_read_ctrl #(
    .DEPTH     (8),
    .MAX_POP   (4),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ren          (ren),
    .rcount       (rcount),
    .flush        (flush),
    .err_clr      (err_clr),
    .w_ptr        (w_ptr),
    .r_ptr        (r_ptr),
    .r_addr       (r_addr),
    .count        (count),
    .empty        (empty),
    .almost_empty (almost_empty),
    .pop_ok       (pop_ok),
    .rd_err       (rd_err),
    .err_sticky   (err_sticky)
  );

  task automatic chk(input string nm, input string field, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s.%s actual=%0d required=%0d", nm, field, act, exp);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] ep;
      e  = exp_q.pop_front();
      ep = e.r_ptr;
      chk(e.name, "r_ptr", int'(r_ptr), int'(e.r_ptr));
      chk(e.name, "r_addr", int'(r_addr), int'(ep[2:0]));
      chk(e.name, "count", int'(count), int'(e.count));
      chk(e.name, "empty", int'(empty), int'(e.empty));
      chk(e.name, "almost_empty", int'(almost_empty), int'(e.ae));
      chk(e.name, "pop_ok", int'(pop_ok), int'(e.pop_ok));
      chk(e.name, "rd_err", int'(rd_err), int'(e.rd_err));
      chk(e.name, "err_sticky", int'(err_sticky), int'(e.sticky));
      $display("txn %-12s rst_n=%0b ren=%0b rc=%0d fl=%0b clr=%0b w=%0d | r=%0d cnt=%0d e=%0b ae=%0b ok=%0b err=%0b st=%0b",
               e.name, rst_n, ren, rcount, flush, err_clr, w_ptr, r_ptr, count,
               empty, almost_empty, pop_ok, rd_err, err_sticky);
    end
  end

  task automatic step(input string nm, input logic rn, input logic en, input logic [2:0] rc,
                      input logic fl, input logic clr, input logic [3:0] w,
                      input logic [3:0] er, input logic [3:0] ecnt, input logic ee,
                      input logic eae, input logic eok, input logic eerr, input logic est);
    exp_t e;
    #1;
    rst_n = rn; ren = en; rcount = rc; flush = fl; err_clr = clr; w_ptr = w;
    e.name = nm; e.r_ptr = er; e.count = ecnt; e.empty = ee; e.ae = eae;
    e.pop_ok = eok; e.rd_err = eerr; e.sticky = est;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ren = 1'b0; rcount = '0; flush = 1'b0; err_clr = 1'b0; w_ptr = '0;
    repeat (2) @(posedge clk);
    //         name          rn en rc fl clr w  | r  cnt e ae ok er st
    step("reset_idle",  1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0);
    step("underflow",   1, 1, 3, 0, 0, 2,   0, 2, 0, 1, 0, 1, 0);
    step("sticky_set",  1, 0, 0, 0, 1, 2,   0, 2, 0, 1, 0, 0, 1);
    step("sticky_clr",  1, 0, 0, 0, 0, 2,   0, 2, 0, 1, 0, 0, 0);
    step("set_wins",    1, 1, 3, 0, 1, 2,   0, 2, 0, 1, 0, 1, 0);
    step("set_held",    1, 0, 0, 0, 1, 2,   0, 2, 0, 1, 0, 0, 1);
    step("clr_again",   1, 0, 0, 0, 0, 5,   0, 5, 0, 0, 0, 0, 0);
    step("pop3",        1, 1, 3, 0, 0, 5,   0, 5, 0, 0, 1, 0, 0);
    step("after_pop3",  1, 0, 7, 0, 0, 5,   3, 2, 0, 1, 0, 0, 0);
    step("cnt_zero",    1, 1, 0, 0, 0, 5,   3, 2, 0, 1, 0, 1, 0);
    step("cnt_big",     1, 1, 5, 0, 0, 11,  3, 8, 0, 0, 0, 1, 1);
    step("err_clr",     1, 0, 0, 0, 1, 11,  3, 8, 0, 0, 0, 0, 1);
    step("pop4a",       1, 1, 4, 0, 0, 11,  3, 8, 0, 0, 1, 0, 0);
    step("pop4b",       1, 1, 4, 0, 0, 11,  7, 4, 0, 0, 1, 0, 0);
    step("pop3b",       1, 1, 3, 0, 0, 15, 11, 4, 0, 0, 1, 0, 0);
    step("wrap_pop",    1, 1, 4, 0, 0, 3,  14, 5, 0, 0, 1, 0, 0);
    step("after_wrap",  1, 0, 0, 0, 0, 3,   2, 1, 0, 1, 0, 0, 0);
    step("flush_pop",   1, 1, 2, 1, 0, 6,   2, 4, 0, 0, 0, 0, 0);
    step("after_flush", 1, 0, 0, 0, 0, 6,   6, 0, 1, 1, 0, 0, 0);
    step("flush_bad",   1, 1, 3, 1, 0, 6,   6, 0, 1, 1, 0, 0, 0);
    step("empty_pop",   1, 1, 1, 0, 0, 6,   6, 0, 1, 1, 0, 1, 0);
    step("full_hi",     1, 0, 0, 0, 0, 14,  6, 8, 0, 0, 0, 0, 1);
    step("rst",         0, 0, 0, 0, 0, 14,  6, 8, 0, 0, 0, 0, 1);
    step("full",        1, 0, 0, 0, 0, 8,   0, 8, 0, 0, 0, 0, 0);
    step("bad5",        1, 1, 5, 0, 0, 8,   0, 8, 0, 0, 0, 1, 0);
    step("pop4c",       1, 1, 4, 0, 0, 8,   0, 8, 0, 0, 1, 0, 1);
    step("reset_pop",   0, 1, 2, 0, 0, 8,   4, 4, 0, 0, 1, 0, 1);
    step("after_reset", 1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0);
    #1;
    ren = 1'b0;
    repeat (3) @(posedge clk);
    check_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
